// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter sequencer with a hardware return-address stack.
// FETCH/EXEC handshake toward instruction memory; one flow-control command is
// accepted per instruction in EXEC.
// Optional feature macro: PC_SEQ_OVF_TRAP_EN.
//   Defined   - stack overflow/underflow traps into FAULT.
//   Undefined - the stack is circular; an empty RET restarts at RESET_PC.
module pc_sequencer #(
  parameter int              AW       = 14,
  parameter int              DEPTH    = 8,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       clr_err,
  input  logic                       cmd_valid,
  input  logic [2:0]                 cmd,
  input  logic                       cond,
  input  logic [AW-1:0]              target,
  output logic [AW-1:0]              pc,
  output logic                       fetch,
  output logic                       decode,
  output logic                       halted,
  output logic                       fault,
  output logic                       ovf,
  output logic                       unf,
  output logic [$clog2(DEPTH+1)-1:0] sp_depth
);

  localparam int SPW = $clog2(DEPTH+1);
  localparam int PW  = $clog2(DEPTH);
  localparam logic [SPW-1:0] SP_FULL  = SPW'(DEPTH);
  localparam logic [PW-1:0]  PTR_LAST = PW'(DEPTH-1);

  localparam logic [2:0] C_JUMP = 3'b001, C_BRANCH = 3'b010, C_SKIP = 3'b011,
                         C_CALL = 3'b100, C_RET    = 3'b101, C_HALT = 3'b110;

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_HALT, S_FAULT} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [PW-1:0]  wr_q, wr_d;      // slot the next push writes
  logic           ovf_q, ovf_d, unf_q, unf_d;
  logic           push;
  logic [AW-1:0]  stack_q [DEPTH];

  logic [AW-1:0] pc_inc, pc_inc2;
  logic [PW-1:0] ptr_inc, ptr_dec;

  assign pc_inc  = pc_q + AW'(1);
  assign pc_inc2 = pc_q + AW'(2);
  // Pointer wraps explicitly so non-power-of-two depths stay in range.
  assign ptr_inc = (wr_q == PTR_LAST) ? '0 : wr_q + PW'(1);
  assign ptr_dec = (wr_q == '0) ? PTR_LAST : wr_q - PW'(1);

  // Next-state, next-PC and stack bookkeeping.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    wr_d    = wr_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    push    = 1'b0;
    if (clr_err) begin
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
    case (state_q)
      S_IDLE:  if (start && !clr_err) state_d = S_FETCH;
      S_FETCH: state_d = S_EXEC;
      S_EXEC: begin
        if (cmd_valid) begin
          state_d = S_FETCH;
          case (cmd)
            C_JUMP:   pc_d = target;
            C_BRANCH: pc_d = cond ? target : pc_inc;
            C_SKIP:   pc_d = cond ? pc_inc2 : pc_inc;
            C_CALL: begin
              if (sp_q == SP_FULL) begin
                ovf_d = 1'b1;
`ifdef PC_SEQ_OVF_TRAP_EN
                state_d = S_FAULT;
`else
                // Full circular stack: overwrite the oldest entry, depth stays.
                push = 1'b1;
                pc_d = target;
                wr_d = ptr_inc;
`endif
              end else begin
                push = 1'b1;
                pc_d = target;
                wr_d = ptr_inc;
                sp_d = sp_q + SPW'(1);
              end
            end
            C_RET: begin
              if (sp_q == '0) begin
                unf_d = 1'b1;
`ifdef PC_SEQ_OVF_TRAP_EN
                state_d = S_FAULT;
`else
                pc_d = RESET_PC;
`endif
              end else begin
                pc_d = stack_q[ptr_dec];
                wr_d = ptr_dec;
                sp_d = sp_q - SPW'(1);
              end
            end
            C_HALT: begin
              pc_d    = pc_inc;
              state_d = S_HALT;
            end
            default: pc_d = pc_inc;  // NEXT and the reserved encoding
          endcase
        end
      end
      S_HALT: if (start && !clr_err) state_d = S_FETCH;
      S_FAULT: begin
        if (clr_err) begin
          state_d = S_IDLE;
          pc_d    = RESET_PC;
          sp_d    = '0;
          wr_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control state and PC registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      sp_q    <= '0;
      wr_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      wr_q    <= wr_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Return-address storage; contents are meaningless beyond sp_q so no reset.
  always_ff @(posedge clk) begin
    if (push) stack_q[wr_q] <= pc_inc;
  end

  assign pc       = pc_q;
  assign fetch    = (state_q == S_FETCH);
  assign decode   = (state_q == S_EXEC);
  assign halted   = (state_q == S_HALT);
  assign fault    = (state_q == S_FAULT);
  assign ovf      = ovf_q;
  assign unf      = unf_q;
  assign sp_depth = sp_q;

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Parametrised program-counter sequencer with a hardware return-address stack. It is the next generation of the fixed-width fetch/decode PC unit and sits between instruction memory and the datapath control unit. It drives a fetch/decode strobe pair, accepts one decoded flow-control command per instruction, and computes the next PC. Supported commands are next, jump, conditional branch, conditional skip, call, return and halt. Stack depth is bounded, and overflow/underflow are detected.

## Interface
Parameters:
- AW, 14, PC/address width in bits
- DEPTH, 8, return-stack entries (≥2)
- RESET_PC, 0, PC value after reset, and the restart value

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; leaves IDLE or HALT
- clr_err  in  1  pulse; clears FAULT and error flags
- cmd_valid  in  1  cmd/cond/target valid this cycle
- cmd  in  3  000 NEXT, 001 JUMP, 010 BRANCH, 011 SKIP, 100 CALL, 101 RET, 110 HALT, 111 reserved (treated as NEXT)
- cond  in  1  condition for BRANCH/SKIP
- target  in  AW  jump/branch/call address
- pc  out  AW  current program counter
- fetch  out  1  high in FETCH state
- decode  out  1  high in EXEC state
- halted  out  1  high in HALT
- fault  out  1  high in FAULT
- ovf  out  1  sticky; CALL issued with stack full
- unf  out  1  sticky; RET issued with stack empty
- sp_depth  out  $clog2(DEPTH+1)  current stack occupancy

## Operation
- FSM states: IDLE, FETCH, EXEC, HALT, FAULT.
- IDLE: waits for start, then goes to FETCH.
- FETCH: fetch=1 for exactly one cycle; memory samples pc. Always goes to EXEC next.
- EXEC: decode=1. While cmd_valid=0, the FSM stays in EXEC (stall) with pc held. When cmd_valid=1, the next PC below is registered and the FSM goes to FETCH.
- Next-PC rules; all arithmetic is modulo 2^AW, so PC+1 at all-ones wraps to 0:
  - NEXT: pc+1
  - JUMP: target
  - BRANCH: target if cond, else pc+1
  - SKIP: pc+2 if cond, else pc+1
  - CALL: push pc+1, then pc=target
  - RET: pc=pop
  - HALT: pc+1, then go to HALT instead of FETCH
- HALT: start resumes at FETCH with the held pc.
- Stack is LIFO; sp_depth increments on push and decrements on pop.
- start outside IDLE/HALT is ignored.
- clr_err: clears ovf/unf in any state; in FAULT it also goes to IDLE with pc=RESET_PC and the stack emptied.
- If clr_err and start are asserted in the same cycle, clr_err wins.

## Timing
- Reset (async assert, sync release):
  - state=IDLE, pc=RESET_PC, sp_depth=0
  - fetch, decode, halted, fault, ovf, unf all =0
  - stack contents are don't-care
- All outputs are registered, or decoded directly from registered state.
- Minimum of 2 cycles per instruction (FETCH, EXEC). Each stalled EXEC cycle adds 1.
- pc and sp_depth update on the clock edge that ends the accepting EXEC cycle; the new pc is visible during the following FETCH.
- Reset asserted mid-instruction aborts immediately; no partial push or pop survives.

## Configuration
- Macro PC_SEQ_OVF_TRAP_EN.
- Defined:
  - CALL with sp_depth=DEPTH sets ovf, performs no push, leaves pc unchanged, and goes to FAULT.
  - RET with sp_depth=0 sets unf, leaves pc unchanged, and goes to FAULT.
- Undefined:
  - The stack is circular. CALL when full overwrites the oldest entry, jumps to target, and keeps sp_depth=DEPTH.
  - RET when empty loads RESET_PC and goes to FETCH.
  - ovf/unf are still set (sticky); fault is never asserted.

## Test plan
- Reset, then start, then NEXT ×3: pc goes 0→1→2→3; fetch/decode alternate each cycle with no gaps.
- pc=5, CALL target=0x100, then RET: pc=0x100 with sp_depth=1, then pc=6 with sp_depth=0.
- BRANCH cond=0/1 and SKIP cond=1 at pc=0x3FFF with AW=14:
  - BRANCH cond=0: pc=0
  - BRANCH cond=1: pc=target
  - SKIP cond=1: pc=1
- Hold cmd_valid=0 for 4 cycles in EXEC: decode stays high, pc is unchanged, and the instruction completes one cycle after cmd_valid=1.
- With DEPTH=8, issue 9 CALLs:
  - With trap enabled: fault=1, ovf=1, pc=8th target; clr_err then gives IDLE with pc=RESET_PC.
  - Without trap: 9th target is reached with sp_depth=8; nine RETs return the 8 newest return addresses, then RESET_PC.
- HALT then start; and rst_n low during EXEC of a CALL: HALT gives halted=1 with pc+1 held, and start resumes at FETCH; the reset gives IDLE with pc=RESET_PC and sp_depth=0.
